imembus_wbc_pipe: RTL and testbench

Parametrised instruction-fetch Wishbone controller. It sits between the CPU fetch stage and the instruction Wishbone bus. It accepts fetch requests into an in-order request queue of configurable depth, so the CPU can run ahead instead of stalling on every fetch. It issues back-to-back classic Wishbone read cycles and returns one registered response per accepted request, with error, unaligned and flush handling.

---
 rtl/imembus_wbc_pipe_if.sv | 24 ++
 rtl/imembus_wbc_pipe.sv | 171 +++++++++++++++++
 tb/tb_imembus_wbc_pipe.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imembus_wbc_pipe_if.sv
// Classic Wishbone bus bundle shared by the instruction-fetch controller and its slaves.
interface Wishbone #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data_rd;
    logic [31:0]       data_wr;
    logic [3:0]        sel;
    logic              we;
    logic              cyc;
    logic              stb;
    logic              ack;
    logic              err;

    modport Controller (
        output addr, data_wr, sel, we, cyc, stb,
        input  data_rd, ack, err
    );

    modport Peripheral (
        input  addr, data_wr, sel, we, cyc, stb,
        output data_rd, ack, err
    );
endinterface

// File: rtl/imembus_wbc_pipe.sv
// Instruction-fetch Wishbone controller with an in-order request queue and back-to-back reads.
// Flush/discard support is compiled in only when IMEMBUS_FLUSH_EN is defined.
module imembus_wbc_pipe #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    Wishbone.Controller       wb,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_re,
    output logic              o_ready,
    output logic [31:0]       o_data,
    output logic [ADDR_W-1:0] o_read_addr,
    output logic              o_valid,
    output logic              o_error,
    output logic              o_unaligned,
    input  logic              i_flush,
    output logic              o_busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic {ST_IDLE, ST_BUS} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       data_reg;
    logic [ADDR_W-1:0] read_addr_reg;
    logic              valid_reg, error_reg, unaligned_reg;
    logic [ADDR_W-1:0] queue_mem [DEPTH];

    logic flush;
    logic discard_reg;
    logic stb;
    logic bus_done;
    logic accept, reject, pop, resp;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef IMEMBUS_FLUSH_EN
    logic discard_next;

    assign flush = i_flush;

    // A flushed cycle still has to finish on the bus; remember to swallow its response.
    always_comb begin
        discard_next = discard_reg;
        if (stb && bus_done)
            discard_next = 1'b0;
        else if (stb && flush)
            discard_next = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            discard_reg <= 1'b0;
        else
            discard_reg <= discard_next;
    end
`else
    logic flush_unused;

    assign flush        = 1'b0;
    assign discard_reg  = 1'b0;
    assign flush_unused = i_flush;
`endif

    assign stb      = (state_reg == ST_BUS);
    assign bus_done = wb.ack | wb.err;

    assign o_ready = (count_reg < DEPTH_C);
    assign o_busy  = (count_reg != '0) || stb;
    assign accept  = i_re && o_ready && (i_addr[1:0] == 2'b00) && !flush;
    assign reject  = i_re && o_ready && (i_addr[1:0] != 2'b00) && !flush;

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        resp       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0 && !flush) begin
                    pop        = 1'b1;
                    state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                if (bus_done) begin
                    resp = !discard_reg && !flush;
                    // Keep stb asserted across responses while work is queued.
                    if (count_reg != '0 && !flush)
                        pop = 1'b1;
                    else
                        state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (flush)
            count_next = '0;
        else if (accept && !pop)
            count_next = count_reg + 1'b1;
        else if (!accept && pop)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (accept)
            queue_mem[wr_ptr_reg] <= i_addr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            addr_reg      <= '0;
            data_reg      <= '0;
            read_addr_reg <= '0;
            valid_reg     <= 1'b0;
            error_reg     <= 1'b0;
            unaligned_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (flush) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end else begin
                if (accept)
                    wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                if (pop)
                    rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (pop)
                addr_reg <= queue_mem[rd_ptr_reg];
            valid_reg     <= resp;
            error_reg     <= resp && wb.err;
            unaligned_reg <= reject;
            if (resp) begin
                data_reg      <= wb.data_rd;
                read_addr_reg <= addr_reg;
            end
        end
    end

    assign wb.addr    = addr_reg;
    assign wb.stb     = stb;
    assign wb.cyc     = stb;
    assign wb.we      = 1'b0;
    assign wb.sel     = 4'b1111;
    assign wb.data_wr = '0;

    assign o_data      = data_reg;
    assign o_read_addr = read_addr_reg;
    assign o_valid     = valid_reg;
    assign o_error     = error_reg;
    assign o_unaligned = unaligned_reg;
endmodule

// File: tb/tb_imembus_wbc_pipe.sv
// Directed bench for imembus_wbc_pipe: vector table plus hand sequences for multi-cycle cases.
module tb_imembus_wbc_pipe;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 2;
    localparam logic [31:0] KEY      = 32'hC0DE_0000;
    localparam logic [31:0] ERR_ADDR = 32'h0000_0200;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_re = 1'b0;
    logic              i_flush = 1'b0;
    logic              o_ready;
    logic [31:0]       o_data;
    logic [ADDR_W-1:0] o_read_addr;
    logic              o_valid;
    logic              o_error;
    logic              o_unaligned;
    logic              o_busy;

    always #5 i_clk = ~i_clk;

    Wishbone #(.ADDR_W(ADDR_W)) wb ();

    imembus_wbc_pipe #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .wb          (wb),
        .i_addr      (i_addr),
        .i_re        (i_re),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_read_addr (o_read_addr),
        .o_valid     (o_valid),
        .o_error     (o_error),
        .o_unaligned (o_unaligned),
        .i_flush     (i_flush),
        .o_busy      (o_busy)
    );

    // Slave: acks (or errs on ERR_ADDR) after wait_cfg wait states; data is address XOR KEY.
    int  wait_cfg = 0;
    int  wcnt;
    wire slv_done = wb.stb && wb.cyc && (wcnt >= wait_cfg);
    assign wb.ack     = slv_done && (wb.addr != ERR_ADDR);
    assign wb.err     = slv_done && (wb.addr == ERR_ADDR);
    assign wb.data_rd = wb.addr ^ KEY;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            wcnt <= 0;
        else if (wb.stb && !slv_done)
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t rq[$];
    int    unal_total = 0;
    int    stb_rise_total = 0;
    logic  stb_prev = 1'b0;

    always @(negedge i_clk) begin
        if (o_valid)
            rq.push_back({o_read_addr, o_data, o_error});
        if (o_unaligned)
            unal_total <= unal_total + 1;
        if (wb.stb && !stb_prev)
            stb_rise_total <= stb_rise_total + 1;
        stb_prev <= wb.stb;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        int          wait_n;
        logic        exp_unal;
        logic        exp_err;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    initial begin
        int    base_r, base_u, base_s, n, ready_low;
        resp_t r;

        vecs[0] = '{32'h0000_0200, 0, 1'b0, 1'b1};
        vecs[1] = '{32'h0000_0204, 0, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0102, 0, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0103, 0, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0040, 3, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_7FFC, 1, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0201, 0, 1'b1, 1'b0};

        // Reset values
        #12;
        check("rst_valid", o_valid, 0);
        check("rst_error", o_error, 0);
        check("rst_unaligned", o_unaligned, 0);
        check("rst_busy", o_busy, 0);
        check("rst_ready", o_ready, 1);
        check("rst_data", o_data, 0);
        check("rst_read_addr", o_read_addr, 0);
        check("rst_stb", wb.stb, 0);
        check("rst_cyc", wb.cyc, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // Single fetch, zero-wait: accept at N, stb from N+1, o_valid after ack at N+2
        wait_cfg = 0;
        base_r = rq.size();
        i_re = 1'b1; i_addr = 32'h100;
        tick();
        i_re = 1'b0; i_addr = '0;
        check("single_stb_n", wb.stb, 0);
        check("single_busy_n", o_busy, 1);
        tick();
        check("single_stb_n1", wb.stb, 1);
        check("single_wb_addr", wb.addr, 32'h100);
        check("single_we", wb.we, 0);
        check("single_sel", wb.sel, 4'hF);
        check("single_data_wr", wb.data_wr, 0);
        tick();
        check("single_valid", o_valid, 1);
        check("single_read_addr", o_read_addr, 32'h100);
        check("single_data", o_data, 32'h100 ^ KEY);
        check("single_error", o_error, 0);
        check("single_stb_end", wb.stb, 0);
        tick();
        check("single_valid_pulse", o_valid, 0);
        check("single_resp_count", rq.size() - base_r, 1);

        // Vector table: one request each, fixed observation window
        for (int v = 0; v < NV; v++) begin
            wait_cfg = vecs[v].wait_n;
            base_r = rq.size(); base_u = unal_total; base_s = stb_rise_total;
            i_re = 1'b1; i_addr = vecs[v].addr;
            tick();
            i_re = 1'b0; i_addr = '0;
            repeat (12) tick();
            if (vecs[v].exp_unal) begin
                check($sformatf("v%0d_unal_pulse", v), unal_total - base_u, 1);
                check($sformatf("v%0d_unal_no_bus", v), stb_rise_total - base_s, 0);
                check($sformatf("v%0d_unal_no_valid", v), rq.size() - base_r, 0);
            end else begin
                check($sformatf("v%0d_resp_count", v), rq.size() - base_r, 1);
                check($sformatf("v%0d_no_unal", v), unal_total - base_u, 0);
                if (rq.size() > base_r) begin
                    r = rq[base_r];
                    check($sformatf("v%0d_addr", v), r.addr, vecs[v].addr);
                    check($sformatf("v%0d_data", v), r.data, vecs[v].addr ^ KEY);
                    check($sformatf("v%0d_err", v), r.err, vecs[v].exp_err);
                end
            end
            check($sformatf("v%0d_idle_busy", v), o_busy, 0);
        end

        // Four back-to-back fetches, 1-wait slave
        wait_cfg = 1;
        base_r = rq.size(); base_s = stb_rise_total; ready_low = 0;
        for (int k = 0; k < 4; k++) begin
            i_re = 1'b1; i_addr = 32'(k * 4);
            n = 0;
            while (!o_ready && n < 20) begin
                ready_low++;
                tick();
                n++;
            end
            tick();
        end
        i_re = 1'b0; i_addr = '0;
        repeat (15) tick();
        check("b2b_ready_low_seen", (ready_low > 0), 1);
        check("b2b_resp_count", rq.size() - base_r, 4);
        check("b2b_stb_rises", stb_rise_total - base_s, 1);
        for (int k = 0; k < 4; k++) begin
            if (rq.size() > base_r + k) begin
                r = rq[base_r + k];
                check($sformatf("b2b_addr%0d", k), r.addr, 32'(k * 4));
                check($sformatf("b2b_data%0d", k), r.data, 32'(k * 4) ^ KEY);
            end
        end

`ifdef IMEMBUS_FLUSH_EN
        // Flush during the 0x0 cycle; only the later 0x40 fetch may respond
        wait_cfg = 3;
        base_r = rq.size();
        for (int k = 0; k < 3; k++) begin
            i_re = 1'b1; i_addr = 32'(k * 4);
            n = 0;
            while (!o_ready && n < 20) begin
                tick();
                n++;
            end
            tick();
        end
        check("flush_in_cycle_stb", wb.stb, 1);
        check("flush_in_cycle_addr", wb.addr, 0);
        i_flush = 1'b1; i_re = 1'b1; i_addr = 32'h80;
        tick();
        i_flush = 1'b0; i_re = 1'b1; i_addr = 32'h40;
        tick();
        i_re = 1'b0; i_addr = '0;
        repeat (20) tick();
        check("flush_resp_count", rq.size() - base_r, 1);
        if (rq.size() > base_r) begin
            r = rq[base_r];
            check("flush_resp_addr", r.addr, 32'h40);
            check("flush_resp_data", r.data, 32'h40 ^ KEY);
        end
        check("flush_idle_busy", o_busy, 0);
`endif

        // Asynchronous reset while a bus cycle is active
        wait_cfg = 5;
        i_re = 1'b1; i_addr = 32'h300;
        tick();
        i_re = 1'b0; i_addr = '0;
        n = 0;
        while (!wb.stb && n < 10) begin
            tick();
            n++;
        end
        check("arst_stb_before", wb.stb, 1);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_stb_drop", wb.stb, 0);
        check("arst_ready", o_ready, 1);
        check("arst_busy", o_busy, 0);
        base_r = rq.size();
        repeat (2) tick();
        i_rst_n = 1'b1;
        repeat (10) tick();
        check("arst_no_stale_valid", rq.size() - base_r, 0);
        check("arst_busy_after", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
